// File: rtl/ppg_window_reader.sv
// Streams a window of samples from RAM port B through a 2-entry output FIFO with valid/ready.
// Optional feature macro WINDOW_SUM_EN adds the win_sum accumulator port.
module ppg_window_reader #(
    parameter int unsigned DATA_W = 22,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 1503
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
`ifdef WINDOW_SUM_EN
    ,
    output logic [DATA_W+ADDR_W-1:0] win_sum
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remain;
    logic              r_inflight;
    logic              r_inflight_last;
    logic [DATA_W-1:0] r_head;
    logic              r_head_last;
    logic              r_head_valid;
    logic [DATA_W-1:0] r_tail;
    logic              r_tail_last;
    logic              r_tail_valid;

    state_t            w_state_next;
    logic              w_accept;
    logic              w_issue;
    logic              w_done_next;
    logic              w_err_next;
    logic              w_pop;
    logic [1:0]        w_count;
    logic [2:0]        w_occ;
    logic [ADDR_W-1:0] w_len_clamped;

    assign w_pop         = r_head_valid & out_ready;
    assign w_count       = {1'b0, r_head_valid} + {1'b0, r_tail_valid};
    // Slots already claimed in the FIFO once this cycle's pop is taken into account.
    assign w_occ         = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_len_clamped = (len > DEPTH_A) ? DEPTH_A : len;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_issue      = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (base_addr >= DEPTH_A) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                    end else if (len == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_accept     = 1'b1;
                        w_state_next = S_READ;
                    end
                end
            end
            S_READ: begin
                if (w_occ < 3'd2) begin
                    w_issue = 1'b1;
                    if (r_remain == ADDR_W'(1)) w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_head_last) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_addr          <= '0;
            r_remain        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_head          <= '0;
            r_head_last     <= 1'b0;
            r_head_valid    <= 1'b0;
            r_tail          <= '0;
            r_tail_last     <= 1'b0;
            r_tail_valid    <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_busy          <= (w_state_next != S_IDLE);
            r_done          <= w_done_next;
            r_err           <= w_err_next;
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remain == ADDR_W'(1));

            if (w_accept) begin
                r_addr   <= base_addr;
                r_remain <= w_len_clamped;
            end else if (w_issue) begin
                r_addr   <= (r_addr == LAST_A) ? '0 : r_addr + ADDR_W'(1);
                r_remain <= r_remain - ADDR_W'(1);
            end

            // Head is the presented beat; tail only fills while the head is stalled.
            if (w_pop) begin
                if (r_tail_valid) begin
                    r_head       <= r_tail;
                    r_head_last  <= r_tail_last;
                    r_tail       <= ram_q;
                    r_tail_last  <= r_inflight_last;
                    r_tail_valid <= r_inflight;
                end else begin
                    r_head       <= ram_q;
                    r_head_last  <= r_inflight_last;
                    r_head_valid <= r_inflight;
                end
            end else if (r_inflight) begin
                if (!r_head_valid) begin
                    r_head       <= ram_q;
                    r_head_last  <= r_inflight_last;
                    r_head_valid <= 1'b1;
                end else begin
                    r_tail       <= ram_q;
                    r_tail_last  <= r_inflight_last;
                    r_tail_valid <= 1'b1;
                end
            end
        end
    end

`ifdef WINDOW_SUM_EN
    localparam int unsigned SUM_W = DATA_W + ADDR_W;
    logic [SUM_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sum <= '0;
        end else if (w_accept) begin
            r_sum <= '0;
        end else if (w_pop) begin
            r_sum <= r_sum + SUM_W'(r_head);
        end
    end

    assign win_sum = r_sum;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign ram_addr  = r_addr;
    assign ram_we    = 1'b0;
    assign out_data  = r_head;
    assign out_valid = r_head_valid;
    assign out_last  = r_head_last;

endmodule

// File: tb/tb_ppg_window_reader.sv
// Randomized bench for ppg_window_reader: RAM model plus a queue-based window reference.
// Build with WINDOW_SUM_EN defined to also check win_sum.
module tb_ppg_window_reader;

    localparam int unsigned DATA_W = 22;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DEPTH  = 1503;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] len = '0;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_q = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
`ifdef WINDOW_SUM_EN
    logic [DATA_W+ADDR_W-1:0] win_sum;
`endif

    logic [DATA_W-1:0] mem [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    ppg_window_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_q     (ram_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
`ifdef WINDOW_SUM_EN
        ,
        .win_sum   (win_sum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM with one cycle of latency.
    always @(posedge clk) ram_q <= (32'(ram_addr) < DEPTH) ? mem[ram_addr] : '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc - 1) % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run_window(input int base, input int ln, input int mode, input bit poke);
        logic [DATA_W:0] exp_q[$];
        logic [63:0]     exp_sum;
        int              eff;
        int              cyc;
        int              first_c;
        int              done_c;
        eff     = (ln > int'(DEPTH)) ? int'(DEPTH) : ln;
        exp_sum = '0;
        for (int k = 0; k < eff; k++) begin
            exp_q.push_back({(k == eff - 1), mem[(base + k) % int'(DEPTH)]});
            exp_sum += 64'(mem[(base + k) % int'(DEPTH)]);
        end
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        len       = ADDR_W'(ln);
        out_ready = 1'b1;
        cyc = 0; first_c = -1; done_c = -1;
        while (cyc < 6000) begin
            @(negedge clk);
            cyc++;
            start     = poke && (cyc == 2);
            out_ready = ready_for(mode, cyc);
            #1;
            if (done) begin
                done_c = cyc;
                break;
            end
            check("busy_in_window", busy, 1);
            check("ram_we", ram_we, 0);
            check("addr_range", 64'(32'(ram_addr) < DEPTH), 1);
            if (out_valid) begin
                if (first_c < 0) first_c = cyc;
                if (exp_q.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    check("data", out_data, exp_q[0][DATA_W-1:0]);
                    check("last", out_last, exp_q[0][DATA_W]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
        if (done_c < 0) check("timeout_done", 0, 1);
        check("done_err", err, 0);
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        check("beats_left", exp_q.size(), 0);
        if (mode == 0) begin
            check("first_valid_cycle", first_c, 3);
            check("done_cycle", done_c, 3 + eff);
        end
`ifdef WINDOW_SUM_EN
        check("win_sum", win_sum, exp_sum);
`endif
        @(negedge clk);
        #1;
        check("done_pulse", done, 0);
    endtask

    task automatic run_reject(input int base, input int ln, input logic exp_err);
        @(negedge clk);
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        len       = ADDR_W'(ln);
        @(negedge clk);
        start = 1'b0;
        #1;
        check("rej_done", done, 1);
        check("rej_err", err, 64'(exp_err));
        check("rej_busy", busy, 0);
        check("rej_valid", out_valid, 0);
        @(negedge clk);
        #1;
        check("rej_done_pulse", done, 0);
        check("rej_err_pulse", err, 0);
        check("rej_valid2", out_valid, 0);
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'(i);
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_we", ram_we, 0);
        reset_n = 1'b1;

        run_window(10, 4, 0, 1'b0);
        run_window(1501, 4, 0, 1'b0);
        run_window(200, 8, 1, 1'b0);
        run_window(300, 6, 0, 1'b1);
        run_reject(1600, 4, 1'b1);
        run_reject(1503, 4, 1'b1);
        run_reject(20, 0, 1'b0);

        // Abort a window after two accepted beats.
        @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(100); len = ADDR_W'(10); out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("abort_beat2", out_data, 64'(mem[101]));
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_valid", out_valid, 0);
        check("abort_last", out_last, 0);
        check("abort_addr", ram_addr, 0);
        check("abort_done", done, 0);
`ifdef WINDOW_SUM_EN
        check("abort_sum", win_sum, 0);
`endif
        reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            check("abort_no_done", done, 0);
            check("abort_no_valid", out_valid, 0);
        end
        run_window(0, 2, 0, 1'b0);

        run_window(0, 1503, 0, 1'b0);
`ifdef WINDOW_SUM_EN
        check("t6_sum_const", win_sum, 64'd1128753);
`endif
        run_window(700, 2000, 0, 1'b0);

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom);
        for (int t = 0; t < 14; t++) begin
            run_window(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)),
                       int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end
        run_window(1490, 30, 2, 1'b0);
        run_reject(int'($urandom_range(DEPTH, 2047)), 5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
